ksa_sub_pipe: RTL and testbench
===============================

Name: ksa_sub_pipe

Overview:
- Pipelined Kogge-Stone subtractor: diff = a - b - bin, the inverse operation of the team's Kogge-Stone adder.
- Reuses the same parallel-prefix carry network: operand b and borrow-in are inverted into an add.
- Three register stages with valid/ready handshakes on both sides, so it can sit in a streaming datapath between producer and consumer blocks.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of 2, at least 4.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset: on rst_n low, immediately clear all stage valid bits (v1, v2, v3). out_valid=0, diff=0, bout=0, plus ovf=0 when the optional feature is compiled in. Data registers clear to 0.
- Reset mid-operation: all in-flight results are discarded. Nothing is emitted after rst_n is released until new inputs arrive.
- Arithmetic: compute a + ~b + ~bin. Carry-in c0 = ~bin. Bit generate g_i = a_i & ~b_i, propagate p_i = a_i ^ ~b_i.
  - Prefix combine: (g,p)o(g',p') = (g | p&g', p&p'), with Kogge-Stone span doubling per level.
  - diff_i = p_i ^ c_i.
  - bout = ~c_WIDTH.
- Stage S1 registers g, p, c0 and v1.
- Stage S2 registers the prefix after levels 1..ceil(LEVELS/2) and v2.
- Stage S3 registers the remaining levels, diff, bout and v3. out_valid = v3.
- Latency: exactly 3 cycles from the accepting edge to out_valid, when there is no backpressure. Throughput is 1 result per cycle.
- Handshake:
  - adv = ~v3 | out_ready. in_ready = adv (combinational).
  - When adv=1, every stage shifts forward one position. v1 <= in_valid.
  - When adv=0, all stage registers hold.
  - Bubbles do not collapse.
- Transfers:
  - An input is transferred when in_valid & in_ready.
  - An output is transferred when out_valid & out_ready.
  - diff and bout stay stable while out_valid=1 and out_ready=0.
- Inputs sampled while in_ready=0 are ignored. The producer must hold them.
- Simultaneous output consume and input accept in the same cycle is allowed, giving a full stream.
- Boundaries:
  - a=b, bin=0 gives diff=0, bout=0.
  - a=0, b=2^WIDTH-1, bin=1 gives diff=0, bout=1 (a full wrap).

Optional Feature:
- KSA_SUB_OVF_EN defined: adds output port ovf (1 bit), a signed two's-complement overflow flag.
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb).
  - ovf is pipelined alongside diff with the same latency and stall behaviour, and resets to 0.
- Not defined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then a=0xA8, b=0x75, bin=0, out_ready=1 -> 3 cycles later out_valid=1, diff=0x33, bout=0.
- Stream on consecutive cycles:
  - 0xB9-0xF7 -> diff=0xC2, bout=1.
  - 0xBF-0x2E -> diff=0x91, bout=0.
  - 0x00-0x01 -> diff=0xFF, bout=1.
  - Expected: results appear on 3 consecutive cycles in order; in_ready stays 1 throughout.
- a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1. With KSA_SUB_OVF_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles with 4 inputs offered -> exactly 3 accepted, in_ready=0 once S3 is full, diff held stable. Release -> all 3 results delivered in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 2 operations in flight -> out_valid drops immediately. After release, no stale results appear.
- Random: 10k random a, b, bin with random out_ready -> every output equals the reference model {bout,diff} = {a < b+bin, (a-b-bin) mod 256}, in order.

Source files
------------

// File: rtl/ksa_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor (a - b - bin) with valid/ready handshakes.
// Optional signed-overflow output when KSA_SUB_OVF_EN is defined.
module ksa_sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef KSA_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int SPLIT  = (LEVELS + 1) / 2;

    logic             adv;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d, s1_p_q, s1_p_d;
    logic             s1_c0_q, s1_c0_d;
    logic [WIDTH-1:0] s2_g_q, s2_g_d, s2_gp_q, s2_gp_d, s2_p_q, s2_p_d;
    logic             s2_c0_q, s2_c0_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [WIDTH-1:0] gk2, pk2, gk3, pk3, lowmask2, lowmask3, carries;
`ifdef KSA_SUB_OVF_EN
    logic             s1_am_q, s1_am_d, s1_bm_q, s1_bm_d;
    logic             s2_am_q, s2_am_d, s2_bm_q, s2_bm_d;
    logic             ovf_q, ovf_d;
`endif

    assign adv       = ~v3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef KSA_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

    // S1: subtraction becomes a + ~b + ~bin, so the bit terms use ~b and carry-in is ~bin.
    always_comb begin
        v1_d    = v1_q;
        s1_g_d  = s1_g_q;
        s1_p_d  = s1_p_q;
        s1_c0_d = s1_c0_q;
        if (adv) begin
            v1_d    = in_valid;
            s1_g_d  = a & ~b;
            s1_p_d  = a ^ ~b;
            s1_c0_d = ~bin;
        end
    end

    // S2: carry-in folded into bit 0 generate, then the first SPLIT prefix levels.
    always_comb begin
        gk2      = s1_g_q;
        gk2[0]   = s1_g_q[0] | (s1_p_q[0] & s1_c0_q);
        pk2      = s1_p_q;
        lowmask2 = '0;
        for (int l = 0; l < SPLIT; l++) begin
            lowmask2 = (WIDTH'(1) << (1 << l)) - WIDTH'(1);
            gk2      = gk2 | (pk2 & (gk2 << (1 << l)));
            pk2      = pk2 & ((pk2 << (1 << l)) | lowmask2);
        end
        v2_d    = v2_q;
        s2_g_d  = s2_g_q;
        s2_gp_d = s2_gp_q;
        s2_p_d  = s2_p_q;
        s2_c0_d = s2_c0_q;
        if (adv) begin
            v2_d    = v1_q;
            s2_g_d  = gk2;
            s2_gp_d = pk2;
            s2_p_d  = s1_p_q;
            s2_c0_d = s1_c0_q;
        end
    end

    // S3: remaining prefix levels; gk3[i] is the carry out of bit i.
    always_comb begin
        gk3      = s2_g_q;
        pk3      = s2_gp_q;
        lowmask3 = '0;
        for (int l = SPLIT; l < LEVELS; l++) begin
            lowmask3 = (WIDTH'(1) << (1 << l)) - WIDTH'(1);
            gk3      = gk3 | (pk3 & (gk3 << (1 << l)));
            pk3      = pk3 & ((pk3 << (1 << l)) | lowmask3);
        end
        carries = {gk3[WIDTH-2:0], s2_c0_q};
        v3_d    = v3_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        if (adv) begin
            v3_d   = v2_q;
            diff_d = s2_p_q ^ carries;
            bout_d = ~gk3[WIDTH-1];
        end
    end

`ifdef KSA_SUB_OVF_EN
    always_comb begin
        s1_am_d = s1_am_q;
        s1_bm_d = s1_bm_q;
        s2_am_d = s2_am_q;
        s2_bm_d = s2_bm_q;
        ovf_d   = ovf_q;
        if (adv) begin
            s1_am_d = a[WIDTH-1];
            s1_bm_d = b[WIDTH-1];
            s2_am_d = s1_am_q;
            s2_bm_d = s1_bm_q;
            ovf_d   = (s2_am_q != s2_bm_q) & (diff_d[WIDTH-1] != s2_am_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_am_q <= 1'b0;
            s1_bm_q <= 1'b0;
            s2_am_q <= 1'b0;
            s2_bm_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_am_q <= s1_am_d;
            s1_bm_q <= s1_bm_d;
            s2_am_q <= s2_am_d;
            s2_bm_q <= s2_bm_d;
            ovf_q   <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            s1_g_q  <= '0;
            s1_p_q  <= '0;
            s1_c0_q <= 1'b0;
            s2_g_q  <= '0;
            s2_gp_q <= '0;
            s2_p_q  <= '0;
            s2_c0_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            s1_g_q  <= s1_g_d;
            s1_p_q  <= s1_p_d;
            s1_c0_q <= s1_c0_d;
            s2_g_q  <= s2_g_d;
            s2_gp_q <= s2_gp_d;
            s2_p_q  <= s2_p_d;
            s2_c0_q <= s2_c0_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Directed and random checks of ksa_sub_pipe (WIDTH=8): latency, streaming, backpressure, reset, boundaries.
module tb_ksa_sub_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       bin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready, out_valid, bout, obs_ovf;
    logic [7:0] diff;
    logic [9:0] obs;

`ifdef KSA_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
    logic ovf;
    assign obs_ovf = ovf;
`else
    localparam bit OVF_ON = 1'b0;
    assign obs_ovf = 1'b0;
`endif

    assign obs = {obs_ovf, bout, diff};

    ksa_sub_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff),
`ifdef KSA_SUB_OVF_EN
        .ovf(ovf),
`endif
        .bout(bout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: {ovf, bout, diff}
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       o;
        t = {1'b0, x} - {1'b0, y} - {8'd0, c};
        o = (x[7] != y[7]) && (t[7] != x[7]);
        return {o & OVF_ON, t[8], t[7:0]};
    endfunction

    task automatic run1(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic [9:0] e);
        a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, obs, e);
        step();
    endtask

    logic [7:0] sa [3] = '{8'hB9, 8'hBF, 8'h00};
    logic [7:0] sb [3] = '{8'hF7, 8'h2E, 8'h01};
    logic [9:0] se [3] = '{10'h1C2, 10'h091, 10'h1FF};
    logic [7:0] ba [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [7:0] bb [4] = '{8'd3, 8'd5, 8'd7, 8'd9};
    logic [9:0] exp_q [$];

    initial begin
        int acc, idx;
        bit hold;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", obs_ovf, 0);
        rst_n = 1'b1;
        step();

        // Latency
        a = 8'hA8; b = 8'h75; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        chk("lat_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lat_c1", out_valid, 0);
        step();
        chk("lat_c2", out_valid, 0);
        step();
        chk("lat_c3", out_valid, 1);
        chk("lat_data", obs, {OVF_ON, 1'b0, 8'h33});
        step();
        chk("lat_drain", out_valid, 0);

        // Back-to-back stream
        for (int k = 0; k < 3; k++) begin
            a = sa[k]; b = sb[k]; bin = 1'b0; in_valid = 1'b1;
            chk("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_data", obs, se[k]);
            step();
        end
        chk("stream_end", out_valid, 0);

        // Boundaries
        run1("msb_eq_bin", 8'h80, 8'h80, 1'b1, 10'h1FF);
        run1("a_eq_b", 8'h5A, 8'h5A, 1'b0, 10'h000);
        run1("full_wrap", 8'h00, 8'hFF, 1'b1, 10'h100);
        run1("signed_ovf", 8'h80, 8'h01, 1'b0, {OVF_ON, 1'b0, 8'h7F});

        // Backpressure: 5 stalled cycles, 4 offers
        out_ready = 1'b0; acc = 0; idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            a = ba[idx]; b = bb[idx]; bin = 1'b0; in_valid = 1'b1;
            if (cyc >= 3) begin
                chk("bp_held_valid", out_valid, 1);
                chk("bp_held_data", obs, {2'b00, 8'h07});
            end
            if (in_ready) begin
                acc++;
                idx++;
            end
            step();
        end
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_r0", obs, {2'b00, 8'h07});
        step();
        chk("bp_r1_valid", out_valid, 1);
        chk("bp_r1", obs, {2'b00, 8'h0F});
        step();
        chk("bp_r2_valid", out_valid, 1);
        chk("bp_r2", obs, {2'b00, 8'h17});
        step();
        chk("bp_done", out_valid, 0);

        // Asynchronous reset with work in flight
        for (int k = 1; k <= 3; k++) begin
            a = 8'(k); b = 8'h00; bin = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("mid_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_diff", diff, 0);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_no_stale", out_valid, 0);
        end

        // Random stream with random backpressure, checked in order
        hold = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b, bin));
            hold = in_valid && !in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rand_spurious", out_valid, 0);
                else chk("rand_data", obs, exp_q.pop_front());
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("drain_spurious", out_valid, 0);
                else chk("drain_data", obs, exp_q.pop_front());
            end
            step();
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
